fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side drain engine for the synchronous FIFO. It issues chip-select and read-enable pulses, absorbs the FIFO's one-cycle registered read latency, and presents the data as a valid/ready stream. Every BURST_LEN accepted beats it marks a frame boundary with `m_last`. It sits between the FIFO's read port and any downstream stream consumer, and sustains one beat per cycle when neither side stalls.

## Interface
- `DATA_WIDTH`, 32: width of FIFO word and stream data.
- `BURST_LEN`, 4: beats per frame; legal range 1..256.

- `clk` in 1: single clock, shared with the FIFO.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: permits new FIFO reads; data already buffered or in flight still drains when low.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_data` in DATA_WIDTH: FIFO registered read data.
- `fifo_cs` out 1: FIFO chip select; equals `fifo_rd_en`.
- `fifo_rd_en` out 1: FIFO read strobe; combinational.
- `m_valid` out 1: stream beat valid.
- `m_ready` in 1: stream consumer ready.
- `m_data` out DATA_WIDTH: stream data.
- `m_last` out 1: last beat of frame.
- `busy` out 1: (`count` != 0) | `inflight`.

## Operation
- **FIFO read contract:**
  - A read issued in cycle N (`fifo_cs` & `fifo_rd_en` & !`fifo_empty`) yields the word on `fifo_data` in cycle N+1.
  - `fifo_data` holds its value otherwise.
- **State:**
  - 2-entry output buffer: `count` 0..2, head/tail entries.
  - `inflight` bit: 1 while a read issued last cycle has not yet been captured.
  - Beat counter `beat`: width max(1, clog2(BURST_LEN)).
- **Issue rule:**
  - `fifo_rd_en` = !`rst` & `enable` & !`fifo_empty` & ((`count` + `inflight` − `pop`) < 2), where `pop` = `m_valid` & `m_ready`.
  - Never asserted while `fifo_empty`=1.
- **Capture:** when `inflight`=1, `fifo_data` is written into the buffer tail and `inflight` clears, unless a new read is issued in the same cycle.
- **Output:**
  - `m_valid` = (`count` != 0); `m_data` = head entry.
  - Head advances on `pop`.
  - Capture and pop in the same cycle leave `count` unchanged.
  - Captured data is written directly to the head when `count` is 0, or becomes 1 after the pop.
- **Stream rules:**
  - `m_data` and `m_last` are stable while `m_valid` & !`m_ready`.
  - `m_valid` never drops without a pop.
- **Framing:**
  - `beat` increments on each pop and wraps to 0 after BURST_LEN−1.
  - `m_last` = `m_valid` & (`beat` == BURST_LEN−1).
  - BURST_LEN=1 gives `m_last`=1 on every beat.
- **Reset:**
  - `count`, `inflight`, `beat` = 0.
  - `m_valid` = 0, `m_last` = 0, `m_data` = 0, `busy` = 0.
  - Outputs `fifo_rd_en` = 0 and `fifo_cs` = 0 during reset.
  - Reset mid-operation discards buffered and in-flight words; the FIFO pointer has already advanced, so those words are lost by design.
- **Overflow:** impossible by the issue rule. `count` + `inflight` ≤ 2 at all times; this is a verification assertion.

## Timing
- Empty→stream latency:
  - `fifo_empty` falls in cycle 0 with `enable`=1 → `fifo_rd_en`=1 in cycle 0.
  - Word on `fifo_data` in cycle 1, captured at the end of cycle 1.
  - `m_valid`=1 in cycle 2.
- Steady state with `m_ready`=1 and a non-empty FIFO: one read and one pop per cycle (`count`=1, `inflight`=1).
- `m_ready` low: at most two further reads are issued, then `fifo_rd_en` stays 0 until a pop.
- After `m_ready` returns: the first pop is in the same cycle, and the next read is issued that cycle.
- `enable` deassert: takes effect in the same cycle, since `fifo_rd_en` is combinational; pending words drain normally.

## Structure
- Shared package/header holds the `BURST_LEN` legality check and the localparam for `beat` width.
- One natural sub-module, `skid_buf2`:
  - 2-entry valid/ready buffer with push/pop and `count`.
  - Contains no FIFO knowledge.
- The top level holds the issue logic, `inflight` and the beat counter.

## Test plan
- **Single word:**
  - Write 0xA5A5_0001 into the FIFO with `m_ready`=1.
  - Expect `m_valid` 2 cycles after `fifo_empty` falls, `m_data`=0xA5A5_0001 for exactly 1 cycle.
  - Expect `m_last`=0 with BURST_LEN=4.
- **Full rate:**
  - Preload 8 words 0..7 with `m_ready`=1.
  - Expect 8 consecutive beats 0..7, no gaps.
  - Expect `m_last` on beats 3 and 7.
  - Expect `busy` to fall 1 cycle after beat 7.
- **Backpressure:**
  - Preload 8 words; hold `m_ready`=0 for 10 cycles.
  - Expect exactly 2 reads issued, `m_data`=0 stable, FIFO holding 6 words.
  - Release `m_ready`: remaining beats arrive back to back, in order.
- **Random `m_ready`:**
  - 50% `m_ready` over 1000 random words.
  - Scoreboard: in order, no loss or duplication, `m_data` stable under stall.
  - Assert `count` + `inflight` ≤ 2 and no read while `fifo_empty`.
- **Enable gating:**
  - Drop `enable` after 3 reads issued.
  - Expect buffered/in-flight words delivered and no further reads.
  - Re-enable: resumes with word 3.
- **Mid-stream reset:**
  - Assert `rst` for 1 cycle with `count`=2.
  - Expect `m_valid`=0, `m_last`=0, `beat`=0 next cycle.
  - First post-reset beat restarts framing with `m_last` on the 4th beat.

Source files
------------

// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_reader_pkg
// Shared definitions for the FIFO read-side drain engine: BURST_LEN legality
// check, beat-counter width helper and the buffer occupancy type.
package fifo_stream_reader_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned BURST_LEN_DEF  = 4;
  localparam int unsigned BURST_LEN_MIN  = 1;
  localparam int unsigned BURST_LEN_MAX  = 256;

  // Occupancy of the 2-entry output buffer (0..2).
  typedef logic [1:0] occ_t;

  // Legal frame lengths are 1..256 beats.
  function automatic bit burst_len_ok(input int unsigned n);
    return (n >= BURST_LEN_MIN) && (n <= BURST_LEN_MAX);
  endfunction

  // Beat counter width: max(1, clog2(n)).
  function automatic int unsigned beat_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned BEAT_W_DEF = beat_width(BURST_LEN_DEF);

endpackage

// File: rtl/fifo_stream_reader_skid_buf2.sv
// fifo_stream_reader_skid_buf2
// Two-entry valid/ready holding buffer. Knows nothing about the FIFO: it only
// accepts pushes, releases pops and reports its occupancy.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : write one entry at the tail
//   pop             : release the head entry (caller guarantees count != 0)
//   head            : current head entry
//   count           : number of entries held (0..2)
module fifo_stream_reader_skid_buf2
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output occ_t         count
);

  logic [W-1:0] tail;

  // Head/tail update; head is written directly whenever it would otherwise
  // be empty after this cycle's pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) head <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Read-side drain engine for the synchronous FIFO. Issues read strobes, absorbs
// the FIFO's one-cycle read latency and presents the words as a valid/ready
// stream, marking every BURST_LEN-th accepted beat with m_last.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   enable               : permits new FIFO reads
//   fifo_empty           : FIFO empty flag
//   fifo_data            : FIFO registered read data
//   fifo_cs, fifo_rd_en  : FIFO chip select / read strobe (combinational)
//   m_valid, m_ready     : stream handshake
//   m_data, m_last       : stream payload and frame boundary
//   busy                 : words buffered or a read in flight
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned BURST_LEN  = BURST_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int unsigned BEAT_W = beat_width(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

  if (!burst_len_ok(BURST_LEN)) begin : g_bad_burst_len
    $error("fifo_stream_reader: BURST_LEN must be in 1..256");
  end

  occ_t              count;
  logic              inflight;
  logic [BEAT_W-1:0] beat;
  logic              pop;
  logic [2:0]        load;

  assign pop = m_valid & m_ready;

  // Slots committed after this cycle's pop; a new read needs one free slot.
  assign load       = 3'(count) + 3'(inflight) - 3'(pop);
  assign fifo_rd_en = ~rst & enable & ~fifo_empty & (load < 3'd2);
  assign fifo_cs    = fifo_rd_en;

  // A read issued last cycle delivers its word now; it is always captured.
  fifo_stream_reader_skid_buf2 #(
    .W (DATA_WIDTH)
  ) u_skid_buf2 (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_data),
    .pop       (pop),
    .head      (m_data),
    .count     (count)
  );

  // In-flight tracking and frame beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      beat     <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop) beat <= (beat == BEAT_MAX) ? '0 : beat + BEAT_W'(1);
    end
  end

  assign m_valid = (count != 2'd0);
  assign m_last  = m_valid & (beat == BEAT_MAX);
  assign busy    = (count != 2'd0) | inflight;

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

  localparam int unsigned DW = 32;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          m_ready = 1'b0;
  logic          fifo_cs, fifo_rd_en, m_valid, m_last, busy;
  logic [DW-1:0] m_data;

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_cs    (fifo_cs),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // FIFO contents and reference model: words handed out by the FIFO but not yet
  // accepted downstream, in order.
  logic [31:0] fq[$];
  logic [31:0] sent_q[$];
  int          outstanding = 0;
  bit          prev_rd = 1'b0;
  int          beat_m = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  bit          prev_last = 1'b0;
  int          reads_total = 0;
  int          pops_total = 0;

  bit          o_rd, o_cs, o_valid, o_last, o_busy, o_pop;
  logic [31:0] o_data;

  typedef struct {
    bit          push;
    logic [31:0] word;
    bit          ready;
    bit          en;
    bit          e_rd;
    bit          e_valid;
    logic [31:0] e_data;
    bit          e_last;
    bit          e_busy;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: sample settled outputs, check against the model, then
  // advance the FIFO model and the reference model across the edge.
  task automatic step();
    bit e_valid, e_pop, e_rd;
    fifo_empty = (fq.size() == 0);
    #1;
    o_rd = fifo_rd_en; o_cs = fifo_cs; o_valid = m_valid; o_data = m_data;
    o_last = m_last; o_busy = busy;
    o_pop = o_valid && m_ready;
    if (rst) begin
      chk("rd_en_in_reset", o_rd, 0);
      chk("cs_in_reset", o_cs, 0);
    end else begin
      e_valid = (outstanding - int'(prev_rd)) != 0;
      e_pop   = e_valid && m_ready;
      e_rd    = enable && !fifo_empty && ((outstanding - int'(e_pop)) < 2);
      chk("cs_eq_rd_en", o_cs, o_rd);
      chk("rd_en", o_rd, e_rd);
      chk("no_read_when_empty", o_rd && fifo_empty, 0);
      chk("m_valid", o_valid, e_valid);
      chk("busy", o_busy, outstanding != 0);
      if (e_valid) begin
        if (sent_q.size() > 0) chk("m_data_order", o_data, sent_q[0]);
        chk("m_last", o_last, beat_m == BL - 1);
      end else begin
        chk("m_last_idle", o_last, 0);
      end
      if (prev_stall) begin
        chk("stall_valid", o_valid, 1);
        chk("stall_data", o_data, prev_data);
        chk("stall_last", o_last, prev_last);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      sent_q.delete();
      outstanding = 0;
      prev_rd = 1'b0;
      beat_m = 0;
      prev_stall = 1'b0;
    end else begin
      if (o_rd && o_cs && !fifo_empty) begin
        fifo_data = fq.pop_front();
        sent_q.push_back(fifo_data);
        reads_total++;
        outstanding++;
      end
      if (o_pop) begin
        if (sent_q.size() > 0) void'(sent_q.pop_front());
        outstanding--;
        pops_total++;
        beat_m = (beat_m == BL - 1) ? 0 : beat_m + 1;
      end
      chk("occupancy_le_2", (outstanding <= 2), 1);
      prev_rd    = o_rd && !fifo_empty;
      prev_stall = o_valid && !m_ready;
      prev_data  = o_data;
      prev_last  = o_last;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic push_seq(input int n, input int base);
    for (int i = 0; i < n; i++) fq.push_back(32'(base + i));
  endtask

  function automatic vec_t mk(input bit push, input logic [31:0] word, input bit ready,
                              input bit en, input bit e_rd, input bit e_valid,
                              input logic [31:0] e_data, input bit e_last, input bit e_busy);
    vec_t v;
    v.push = push; v.word = word; v.ready = ready; v.en = en; v.e_rd = e_rd;
    v.e_valid = e_valid; v.e_data = e_data; v.e_last = e_last; v.e_busy = e_busy;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[11];
    int   n, first, lastc, r0, p0, pushed;
    bit [7:0] lastmask;

    // ---- reset state ----
    enable = 1'b1;
    m_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("reset_m_valid", o_valid, 0);
    chk("reset_m_last", o_last, 0);
    chk("reset_m_data", o_data, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_rd_en", o_rd, 0);

    // ---- table: single word latency, enable gating, short stall ----
    tbl[0]  = mk(1, 32'hA5A5_0001, 1, 1, 1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 1);
    tbl[2]  = mk(0, 0, 1, 1, 0, 1, 32'hA5A5_0001, 0, 1);
    tbl[3]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 32'h0000_1111, 1, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 1, 1, 1, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 1);
    tbl[7]  = mk(0, 0, 0, 1, 0, 1, 32'h0000_1111, 0, 1);
    tbl[8]  = mk(0, 0, 0, 1, 0, 1, 32'h0000_1111, 0, 1);
    tbl[9]  = mk(0, 0, 1, 1, 0, 1, 32'h0000_1111, 0, 1);
    tbl[10] = mk(0, 0, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].push) fq.push_back(tbl[i].word);
      m_ready = tbl[i].ready;
      enable  = tbl[i].en;
      step();
      chk($sformatf("tbl%0d_rd_en", i), o_rd, tbl[i].e_rd);
      chk($sformatf("tbl%0d_m_valid", i), o_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) chk($sformatf("tbl%0d_m_data", i), o_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_m_last", i), o_last, tbl[i].e_last);
      chk($sformatf("tbl%0d_busy", i), o_busy, tbl[i].e_busy);
    end

    // ---- full rate: 8 words, back to back, framing, busy fall ----
    enable = 1'b1; m_ready = 1'b1;
    do_reset();
    push_seq(8, 0);
    n = 0; first = -1; lastc = -10; lastmask = '0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (n == 8 && c == lastc + 1) chk("full_busy_fall", o_busy, 0);
      if (o_pop) begin
        if (first < 0) first = c;
        chk("full_data", o_data, 32'(n));
        if (n < 8) lastmask[n] = o_last;
        n++;
        if (n == 8) begin
          lastc = c;
          chk("full_busy_at_last", o_busy, 1);
        end
      end
    end
    chk("full_beats", n, 8);
    chk("full_first_cycle", first, 2);
    chk("full_no_gaps", lastc - first, 7);
    chk("full_last_mask", lastmask, 8'h88);

    // ---- backpressure ----
    do_reset();
    m_ready = 1'b0;
    push_seq(8, 0);
    r0 = reads_total;
    for (int c = 0; c < 10; c++) begin
      step();
      if (o_valid) chk("bp_hold_data", o_data, 0);
    end
    chk("bp_reads", reads_total - r0, 2);
    chk("bp_fifo_left", fq.size(), 6);
    chk("bp_valid", o_valid, 1);
    m_ready = 1'b1;
    n = 0; first = -1; lastc = -1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (o_pop) begin
        if (first < 0) first = c;
        chk("bp_order", o_data, 32'(n));
        n++;
        lastc = c;
      end
    end
    chk("bp_beats", n, 8);
    chk("bp_first_pop", first, 0);
    chk("bp_back_to_back", lastc - first, 7);

    // ---- random m_ready, 1000 random words ----
    do_reset();
    p0 = pops_total;
    pushed = 0;
    for (int c = 0; c < 30000 && (pops_total - p0) < 1000; c++) begin
      if (pushed < 1000 && $urandom_range(0, 2) != 0) begin
        fq.push_back($urandom);
        pushed++;
      end
      m_ready = 1'($urandom_range(0, 1));
      enable  = ($urandom_range(0, 9) != 0);
      step();
    end
    chk("rand_beats", pops_total - p0, 1000);
    chk("rand_fifo_drained", fq.size(), 0);
    chk("rand_model_drained", sent_q.size(), 0);

    // ---- enable gating ----
    enable = 1'b1; m_ready = 1'b1;
    do_reset();
    push_seq(8, 0);
    r0 = reads_total;
    p0 = pops_total;
    for (int c = 0; c < 10 && (reads_total - r0) < 3; c++) step();
    enable = 1'b0;
    for (int c = 0; c < 8; c++) step();
    chk("en_reads_stop", reads_total - r0, 3);
    chk("en_drained", pops_total - p0, 3);
    chk("en_idle_busy", o_busy, 0);
    enable = 1'b1;
    n = 0;
    for (int c = 0; c < 10 && n == 0; c++) begin
      step();
      if (o_pop) begin
        chk("en_resume_word", o_data, 3);
        n++;
      end
    end
    chk("en_resumed", n, 1);

    // ---- mid-stream reset with two buffered words ----
    do_reset();
    fq.delete();
    m_ready = 1'b0;
    push_seq(8, 0);
    r0 = reads_total;
    for (int c = 0; c < 5; c++) step();
    chk("mr_buffered", reads_total - r0, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_ready = 1'b1;
    step();
    chk("mr_m_valid", o_valid, 0);
    chk("mr_m_last", o_last, 0);
    chk("mr_m_data", o_data, 0);
    chk("mr_busy", o_busy, 0);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (o_pop) begin
        chk("mr_word", o_data, 32'(n + 2));
        chk("mr_framing", o_last, (n == 3));
        n++;
      end
    end
    chk("mr_beats", n, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
